chain_relax_core: RTL and testbench
===================================

# chain_relax_core

Parametrised, time-multiplexed successor to the per-node chain core: holds `NODES` signed fixed-point node positions and relaxes them with one shared constraint datapath. A sequencer sweeps node by node for `ITERS` iterations per frame under a start/done handshake. It supports two constraint modes: neighbour smoothing and follow-the-leader segment clamping. Cores chain through prev/next boundary ports. The first core's node 0 tracks the mouse; the last core's final node is a free end.

## Interface
- `NODES`, 5: nodes held by this core (≥2).
- `W`, 32: coordinate width, signed two's complement.
- `CORE_ID`, 1: 1-based core index, used for initial positions.
- `ITERS`, 4: relaxation sweeps per frame (≥1).
- `MAX_SEG`, 64: per-axis maximum segment length in clamp mode.
- `INIT_STEP`, 16: initial x spacing.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  frame request; sampled only in IDLE.
- `mode`  in  1  0 = smoothing, 1 = clamp; latched at start.
- `is_first`  in  1  node 0 anchored to the mouse.
- `is_last`  in  1  node NODES-1 is a free end.
- `prev_x`, `prev_y`  in  W  previous core's last node.
- `next_x`, `next_y`  in  W  next core's first node.
- `x_mouse`, `y_mouse`  in  W  anchor position.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle frame-complete pulse.
- `nodes_x`, `nodes_y`  out  NODES*W  node k occupies bits [(k+1)W-1 : kW]; these are registered positions.

## Operation
- **Reset** (reset=0 at an edge, any state):
  - Global index g = k + (CORE_ID-1)*NODES + 1.
  - x[k] = g*INIT_STEP; y[k] = 0.
  - FSM goes to IDLE; iter/idx cleared; busy = 0; done = 0.
- **IDLE**: on start=1, go to LOAD.
- **LOAD** (1 cycle):
  - Latch mode, is_first, is_last, prev, next and mouse. Later input changes are ignored until the next frame.
  - If is_first: x[0], y[0] ← mouse.
  - idx ← 0, iter ← 0.
- **RELAX** (1 node per cycle, Gauss-Seidel):
  - Update node idx from L and R; results are visible to idx+1 on the next cycle.
  - L = node idx-1, or latched prev when idx = 0.
  - R = node idx+1, or latched next when idx = NODES-1.
  - idx wraps to 0 after NODES-1 and iter increments. After iter = ITERS-1 with idx = NODES-1, go to DONE.
- **DONE**: done = 1 for 1 cycle, then IDLE.
- **Update rules** (each axis independently):
  - Anchored (idx = 0 and is_first): unchanged.
  - Smoothing, interior or core boundary: new = (L + 2*cur + R) >>> 2. Sum is computed in W+2 bits; the arithmetic shift floors; result is truncated to W.
  - Smoothing, free end (idx = NODES-1 and is_last): unchanged.
  - Clamp, any non-anchored node, uses L only:
    - d = cur − L.
    - If d > MAX_SEG: new = L + MAX_SEG.
    - If d < −MAX_SEG: new = L − MAX_SEG.
    - Otherwise new = cur.
    - Computed in W+1 bits; the result wraps mod 2^W.
  - Boundary case: idx = 0 with !is_first uses the latched prev as L.

## Timing
- start sampled at edge t gives:
  - LOAD at t+1.
  - RELAX on edges t+2 … t+1+ITERS*NODES.
  - done high during the cycle after edge t+1+ITERS*NODES; frame latency = ITERS*NODES+2 edges.
- busy is high from edge t+1 through the done cycle inclusive.
- done and busy are registered outputs.
- start is ignored while busy, including in the done cycle. start held high continuously produces back-to-back frames, each separated by one IDLE cycle.
- nodes_x and nodes_y change only at LOAD (anchor) and RELAX edges. They are stable in IDLE and DONE. Consumers sample after done.
- Reset mid-frame: positions return to their initial values at that edge. No done pulse is produced.

## Test plan
- **Reset**, NODES=5, CORE_ID=2: nodes_x = 96, 112, 128, 144, 160; nodes_y = 0; busy = 0; done = 0.
- **Latency**, ITERS=4, NODES=5:
  - start pulse at edge t → busy = 1 from t+1; done = 1 for exactly one cycle after t+21; busy = 0 after it.
  - A second start while busy is ignored.
- **Clamp**, CORE_ID=1, ITERS=1, mode=1, is_first=1, mouse = (1000, 0): x → 1000, 936, 872, 808, 744; y all 0.
- **Smoothing**, CORE_ID=1, ITERS=1, mode=0, is_first=0, is_last=0:
  - Inputs: prev = (0, 64), next = (96, 0).
  - Expected x = 16, 32, 48, 64, 80 (unchanged); y = 16, 4, 1, 0, 0.
- **Negative floor**, smoothing: prev_y = −3, all y = 0 → y[0] = −1 (0x…FFFF).
- **Reset during RELAX** at idx 2: next edge restores initial positions; busy = 0; no done pulse. A fresh start then completes normally.

Source files
------------

// File: rtl/chain_relax_core_if.sv
// chain_relax_core_if: frame handshake, boundary, anchor and node-position bundle for one chain core.
interface chain_relax_core_if #(
    parameter int NODES = 5,
    parameter int W     = 32
);
    logic                 start;
    logic                 mode;
    logic                 is_first;
    logic                 is_last;
    logic [W-1:0]         prev_x;
    logic [W-1:0]         prev_y;
    logic [W-1:0]         next_x;
    logic [W-1:0]         next_y;
    logic [W-1:0]         x_mouse;
    logic [W-1:0]         y_mouse;
    logic                 busy;
    logic                 done;
    logic [NODES*W-1:0]   nodes_x;
    logic [NODES*W-1:0]   nodes_y;

    modport master (
        output start, mode, is_first, is_last, prev_x, prev_y, next_x, next_y, x_mouse, y_mouse,
        input  busy, done, nodes_x, nodes_y
    );

    modport slave (
        input  start, mode, is_first, is_last, prev_x, prev_y, next_x, next_y, x_mouse, y_mouse,
        output busy, done, nodes_x, nodes_y
    );
endinterface

// File: rtl/chain_relax_core.sv
// chain_relax_core: NODES chain positions relaxed one node per cycle (Gauss-Seidel) by a shared
// smoothing/clamp datapath, ITERS sweeps per frame under a start/done handshake.
module chain_relax_core #(
    parameter int NODES     = 5,
    parameter int W         = 32,
    parameter int CORE_ID   = 1,
    parameter int ITERS     = 4,
    parameter int MAX_SEG   = 64,
    parameter int INIT_STEP = 16
) (
    input logic              clk,
    input logic              reset,
    chain_relax_core_if.slave bus
);
    localparam int IXW = $clog2(NODES);
    localparam int ITW = ITERS > 1 ? $clog2(ITERS) : 1;
    localparam logic [IXW-1:0] LAST_IDX = IXW'(NODES - 1);
    localparam logic [ITW-1:0] LAST_ITER = ITW'(ITERS - 1);
    localparam logic signed [W:0] SEG = (W+1)'(MAX_SEG);
    localparam logic signed [W-1:0] SEGW = W'(MAX_SEG);

    typedef enum logic [1:0] {IDLE, LOAD, RELAX, DONE} state_t;

    state_t state, state_n;
    logic [IXW-1:0] idx;
    logic [ITW-1:0] iter;
    logic signed [W-1:0] px [NODES];
    logic signed [W-1:0] py [NODES];
    logic mode_r, first_r, last_r;
    logic signed [W-1:0] prev_x_r, prev_y_r, next_x_r, next_y_r;
    logic signed [W-1:0] cur_x, cur_y, l_x, l_y, r_x, r_y, new_x, new_y;
    logic hold, last_step;

    // Smoothing averages in W+2 bits and floors; clamp limits cur-L per axis, wrapping mod 2^W.
    function automatic logic signed [W-1:0] relax(input logic signed [W-1:0] cur, l, r,
                                                  input logic clamp, input logic keep);
        logic signed [W+1:0] sum;
        logic signed [W+1:0] avg;
        logic signed [W:0] d;
        sum = {{2{l[W-1]}}, l} + {cur[W-1], cur, 1'b0} + {{2{r[W-1]}}, r};
        avg = sum >>> 2;
        d = {cur[W-1], cur} - {l[W-1], l};
        return keep ? cur :
               !clamp ? avg[W-1:0] :
               d > SEG ? l + SEGW :
               d < -SEG ? l - SEGW : cur;
    endfunction

    always_comb begin
        cur_x = px[idx];
        cur_y = py[idx];
        l_x = idx == '0 ? prev_x_r : px[idx - 1'b1];
        l_y = idx == '0 ? prev_y_r : py[idx - 1'b1];
        r_x = idx == LAST_IDX ? next_x_r : px[idx + 1'b1];
        r_y = idx == LAST_IDX ? next_y_r : py[idx + 1'b1];
        hold = (idx == '0 && first_r) || (idx == LAST_IDX && last_r && !mode_r);
        new_x = relax(cur_x, l_x, r_x, mode_r, hold);
        new_y = relax(cur_y, l_y, r_y, mode_r, hold);
        last_step = idx == LAST_IDX && iter == LAST_ITER;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? LOAD : IDLE;
            LOAD:    state_n = RELAX;
            RELAX:   state_n = last_step ? DONE : RELAX;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            iter <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            for (int k = 0; k < NODES; k++) begin
                px[k] <= W'((k + (CORE_ID - 1) * NODES + 1) * INIT_STEP);
                py[k] <= '0;
            end
        end else begin
            state <= state_n;
            bus.busy <= state_n == RELAX || state_n == DONE;
            bus.done <= state_n == DONE;
            if (state == LOAD) begin
                mode_r <= bus.mode;
                first_r <= bus.is_first;
                last_r <= bus.is_last;
                prev_x_r <= bus.prev_x;
                prev_y_r <= bus.prev_y;
                next_x_r <= bus.next_x;
                next_y_r <= bus.next_y;
                idx <= '0;
                iter <= '0;
                if (bus.is_first) begin
                    px[0] <= bus.x_mouse;
                    py[0] <= bus.y_mouse;
                end
            end
            if (state == RELAX) begin
                px[idx] <= new_x;
                py[idx] <= new_y;
                idx <= idx == LAST_IDX ? '0 : idx + 1'b1;
                if (idx == LAST_IDX) iter <= iter + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NODES; k++) begin : g_pack
        assign bus.nodes_x[k*W +: W] = px[k];
        assign bus.nodes_y[k*W +: W] = py[k];
    end
endmodule

// File: tb/tb_chain_relax_core.sv
// tb_chain_relax_core: directed frames on two cores (CORE_ID=2/ITERS=4 and CORE_ID=1/ITERS=1);
// expected positions are queued at start and checked by a monitor on each done pulse.
module tb_chain_relax_core;
    localparam int W = 32;
    localparam int N = 5;
    localparam int VW = N * W;

    typedef struct {
        logic [VW-1:0] x;
        logic [VW-1:0] y;
        string         name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    int compared = 0;
    int mismatched = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int done_edge;

    always #5 clk = ~clk;

    chain_relax_core_if #(.NODES(N), .W(W)) a_if ();
    chain_relax_core_if #(.NODES(N), .W(W)) b_if ();

    chain_relax_core #(.NODES(N), .W(W), .CORE_ID(2), .ITERS(4)) dut_a (
        .clk(clk), .reset(reset_a), .bus(a_if.slave)
    );
    chain_relax_core #(.NODES(N), .W(W), .CORE_ID(1), .ITERS(1)) dut_b (
        .clk(clk), .reset(reset_b), .bus(b_if.slave)
    );

    function automatic logic [VW-1:0] pack5(int v0, int v1, int v2, int v3, int v4);
        logic [VW-1:0] r;
        r = {32'(v4), 32'(v3), 32'(v2), 32'(v1), 32'(v0)};
        return r;
    endfunction

    task automatic check(string name, logic [VW-1:0] act, logic [VW-1:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (a_if.done) begin
            if (qa.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done_a: got done=1, want no frame pending");
            end else begin
                ea = qa.pop_front();
                check({ea.name, "_x"}, a_if.nodes_x, ea.x);
                check({ea.name, "_y"}, a_if.nodes_y, ea.y);
            end
        end
        if (b_if.done) begin
            if (qb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done_b: got done=1, want no frame pending");
            end else begin
                eb = qb.pop_front();
                check({eb.name, "_x"}, b_if.nodes_x, eb.x);
                check({eb.name, "_y"}, b_if.nodes_y, eb.y);
            end
        end
    end

    task automatic drive_b(bit m, bit f, bit l, int pxv, int pyv, int nxv, int nyv, int mxv, int myv);
        b_if.mode = m;
        b_if.is_first = f;
        b_if.is_last = l;
        b_if.prev_x = 32'(pxv);
        b_if.prev_y = 32'(pyv);
        b_if.next_x = 32'(nxv);
        b_if.next_y = 32'(nyv);
        b_if.x_mouse = 32'(mxv);
        b_if.y_mouse = 32'(myv);
    endtask

    task automatic pulse_reset_b();
        @(negedge clk) reset_b = 1'b0;
        @(negedge clk) reset_b = 1'b1;
    endtask

    task automatic frame_b(string name, logic [VW-1:0] ex, logic [VW-1:0] ey);
        bit seen;
        seen = 1'b0;
        qb.push_back('{x: ex, y: ey, name: name});
        @(negedge clk) b_if.start = 1'b1;
        @(negedge clk) b_if.start = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = b_if.done;
        end
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL %s_timeout: got no done in 100 cycles, want done", name);
        end
        @(negedge clk);
    endtask

    initial begin
        a_if.start = 1'b0; a_if.mode = 1'b0; a_if.is_first = 1'b0; a_if.is_last = 1'b0;
        a_if.prev_x = 32'd80; a_if.prev_y = '0; a_if.next_x = 32'd176; a_if.next_y = '0;
        a_if.x_mouse = '0; a_if.y_mouse = '0;
        b_if.start = 1'b0;
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset_a_x", a_if.nodes_x, pack5(96, 112, 128, 144, 160));
        check("reset_a_y", a_if.nodes_y, '0);
        check("reset_a_busy", VW'(a_if.busy), '0);
        check("reset_a_done", VW'(a_if.done), '0);
        check("reset_b_x", b_if.nodes_x, pack5(16, 32, 48, 64, 80));
        check("reset_b_y", b_if.nodes_y, '0);
        reset_a = 1'b1;
        reset_b = 1'b1;

        // Linear chain with matching boundaries is a fixed point of smoothing.
        qa.push_back('{x: pack5(96, 112, 128, 144, 160), y: '0, name: "latency_frame"});
        @(negedge clk) a_if.start = 1'b1;
        @(negedge clk) a_if.start = 1'b0;
        @(negedge clk);
        check("busy_rise", VW'(a_if.busy), VW'(1));
        done_edge = -1;
        for (int n = 2; n < 40 && done_edge < 0; n++) begin
            @(negedge clk);
            a_if.start = n == 5;
            if (a_if.done) done_edge = n;
        end
        a_if.start = 1'b0;
        check("done_edge", VW'(done_edge), VW'(21));
        @(negedge clk);
        check("done_one_cycle", VW'(a_if.done), '0);
        check("busy_fall", VW'(a_if.busy), '0);
        repeat (30) @(negedge clk);
        check("second_start_ignored", VW'(a_if.busy), '0);

        drive_b(1, 1, 1, 0, 0, 0, 0, 1000, 0);
        frame_b("clamp", pack5(1000, 936, 872, 808, 744), '0);
        pulse_reset_b();
        drive_b(1, 0, 1, -200, 100, 0, 0, 0, 0);
        frame_b("clamp_prev", pack5(-136, -72, -8, 56, 80), pack5(36, 0, 0, 0, 0));
        pulse_reset_b();
        drive_b(0, 0, 0, 0, 64, 96, 0, 0, 0);
        frame_b("smooth", pack5(16, 32, 48, 64, 80), pack5(16, 4, 1, 0, 0));
        pulse_reset_b();
        drive_b(0, 0, 0, 0, -3, 96, 0, 0, 0);
        frame_b("neg_floor", pack5(16, 32, 48, 64, 80), pack5(-1, -1, -1, -1, -1));
        pulse_reset_b();
        drive_b(0, 0, 1, 0, 0, 1000, 1000, 0, 0);
        frame_b("free_end", pack5(16, 32, 48, 64, 80), '0);

        pulse_reset_b();
        drive_b(1, 1, 1, 0, 0, 0, 0, 1000, 0);
        @(negedge clk) b_if.start = 1'b1;
        @(negedge clk) b_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_frame_x", b_if.nodes_x, pack5(1000, 936, 48, 64, 80));
        reset_b = 1'b0;
        @(negedge clk) reset_b = 1'b1;
        check("mid_reset_x", b_if.nodes_x, pack5(16, 32, 48, 64, 80));
        check("mid_reset_busy", VW'(b_if.busy), '0);
        repeat (10) @(negedge clk);
        check("mid_reset_no_done", VW'(b_if.busy | b_if.done), '0);
        drive_b(0, 0, 0, 0, 64, 96, 0, 0, 0);
        frame_b("after_reset", pack5(16, 32, 48, 64, 80), pack5(16, 4, 1, 0, 0));

        repeat (5) @(negedge clk);
        check("queue_drain", VW'(qa.size() + qb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
